// File: rtl/alu_pkg.sv
// Shared types, opcode encodings and event tables for the ALU core.
// The testbench imports the same tables so both sides share one definition of an "event".
package alu_pkg;

  typedef enum logic [1:0] {
    OPA_AND  = 2'b00,
    OPA_NAND = 2'b01,
    OPA_OR   = 2'b10,
    OPA_XOR  = 2'b11
  } op_a_e;

  typedef enum logic [1:0] {
    OPB_XNOR = 2'b00,
    OPB_AND  = 2'b01,
    OPB_NOR  = 2'b10,
    OPB_OR   = 2'b11
  } op_b_e;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } mode_e;

  typedef logic [7:0] irq_src_t;

  // Result values that raise an event, indexed by opcode.
  localparam logic [7:0] EVT_A [4] = '{8'hFF, 8'h00, 8'hF8, 8'h83};
  localparam logic [7:0] EVT_B [4] = '{8'hF1, 8'hF4, 8'hF5, 8'hFF};

endpackage

// File: rtl/alu_if.sv
// Operation/interrupt bus between the ALU core and whatever drives it.
// Clock and reset stay outside the interface as plain ports.
interface alu_if #(parameter int DATA_W = 8);

  logic              alu_enable;
  logic              alu_enable_a;
  logic              alu_enable_b;
  logic [1:0]        alu_op_a;
  logic [1:0]        alu_op_b;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic              alu_irq_clr;
  logic [DATA_W-1:0] alu_out;
  logic              alu_irq;
  logic [7:0]        alu_irq_src;
  logic              alu_mode_err;

  modport master (
    output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
           alu_in_a, alu_in_b, alu_irq_clr,
    input  alu_out, alu_irq, alu_irq_src, alu_mode_err
  );

  modport slave (
    input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
           alu_in_a, alu_in_b, alu_irq_clr,
    output alu_out, alu_irq, alu_irq_src, alu_mode_err
  );

endinterface

// File: rtl/alu_event_detect.sv
// Combinational event matcher: flags {opcode, result} pairs listed in the event tables.
// Output is one-hot; bits [3:0] for mode a, [7:4] for mode b, indexed by opcode.
module alu_event_detect
  import alu_pkg::*;
(
  input  mode_e      mode_i,
  input  logic [1:0] op_i,
  input  logic [7:0] result_i,
  output irq_src_t   hit_o
);

  always_comb begin
    hit_o = '0;
    if (mode_i == MODE_A) begin
      if (result_i == EVT_A[op_i]) hit_o[{1'b0, op_i}] = 1'b1;
    end else begin
      if (result_i == EVT_B[op_i]) hit_o[{1'b1, op_i}] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Two-bank bitwise ALU with registered result, sticky event interrupt and mode-error flag.
// All outputs are registered; no input reaches an output combinationally.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic   clk,
  input logic   rst_n,
  alu_if.slave  bus
);

  // The event table only has meaning for byte-wide results.
  if (DATA_W != 8) begin : g_width_check
    $error("alu_core: DATA_W must be 8");
  end

  logic              valid;
  logic              illegal;
  mode_e             mode;
  logic [1:0]        op_sel;
  logic [DATA_W-1:0] result;
  irq_src_t          hit_raw;
  irq_src_t          hit;

  logic [DATA_W-1:0] out_d, out_q;
  irq_src_t          src_d, src_q;
  logic              irq_d, irq_q;
  logic              err_d, err_q;

  assign valid   = bus.alu_enable & (bus.alu_enable_a ^ bus.alu_enable_b);
  assign illegal = bus.alu_enable & ~(bus.alu_enable_a ^ bus.alu_enable_b);
  assign mode    = bus.alu_enable_b ? MODE_B : MODE_A;
  assign op_sel  = (mode == MODE_A) ? bus.alu_op_a : bus.alu_op_b;

  always_comb begin
    result = '0;
    if (mode == MODE_A) begin
      case (op_a_e'(bus.alu_op_a))
        OPA_AND:  result = bus.alu_in_a & bus.alu_in_b;
        OPA_NAND: result = ~(bus.alu_in_a & bus.alu_in_b);
        OPA_OR:   result = bus.alu_in_a | bus.alu_in_b;
        OPA_XOR:  result = bus.alu_in_a ^ bus.alu_in_b;
        default:  result = '0;
      endcase
    end else begin
      case (op_b_e'(bus.alu_op_b))
        OPB_XNOR: result = ~(bus.alu_in_a ^ bus.alu_in_b);
        OPB_AND:  result = bus.alu_in_a & bus.alu_in_b;
        OPB_NOR:  result = ~(bus.alu_in_a | bus.alu_in_b);
        OPB_OR:   result = bus.alu_in_a | bus.alu_in_b;
        default:  result = '0;
      endcase
    end
  end

  alu_event_detect u_event_detect (
    .mode_i   (mode),
    .op_i     (op_sel),
    .result_i (result[7:0]),
    .hit_o    (hit_raw)
  );

  assign hit = valid ? hit_raw : '0;

  // A new event survives a simultaneous clear: clear first, then OR in the hit.
  always_comb begin
    out_d = valid ? result : out_q;
    src_d = (bus.alu_irq_clr ? irq_src_t'('0) : src_q) | hit;
    irq_d = |src_d;
    err_d = illegal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      src_q <= '0;
      irq_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      src_q <= src_d;
      irq_q <= irq_d;
      err_q <= err_d;
    end
  end

  assign bus.alu_out      = out_q;
  assign bus.alu_irq_src  = src_q;
  assign bus.alu_irq      = irq_q;
  assign bus.alu_mode_err = err_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: stimulus pushes expected outputs into a queue,
// a monitor pops one entry after every clock edge that follows a driven vector.
module tb_alu_core;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] out;
    logic       irq;
    logic [7:0] src;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;
  bit   stim_done;

  alu_if #(.DATA_W(8)) bus ();

  alu_core #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs on the falling edge and queue what must appear after the next rise.
  task automatic step(input logic rst, input logic en, input logic ea, input logic eb,
                      input logic [1:0] opa, input logic [1:0] opb,
                      input logic [7:0] a, input logic [7:0] b, input logic clr,
                      input logic [7:0] e_out, input logic e_irq,
                      input logic [7:0] e_src, input logic e_err);
    exp_t e;
    @(negedge clk);
    rst_n            = rst;
    bus.alu_enable   = en;
    bus.alu_enable_a = ea;
    bus.alu_enable_b = eb;
    bus.alu_op_a     = opa;
    bus.alu_op_b     = opb;
    bus.alu_in_a     = a;
    bus.alu_in_b     = b;
    bus.alu_irq_clr  = clr;
    e.out = e_out;
    e.irq = e_irq;
    e.src = e_src;
    e.err = e_err;
    exp_q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (bus.alu_out !== e.out || bus.alu_irq !== e.irq ||
            bus.alu_irq_src !== e.src || bus.alu_mode_err !== e.err) begin
          tests_failed++;
          $display("FAIL vec%0d: got out=%h irq=%b src=%h err=%b, expected out=%h irq=%b src=%h err=%b",
                   tests_run, bus.alu_out, bus.alu_irq, bus.alu_irq_src, bus.alu_mode_err,
                   e.out, e.irq, e.src, e.err);
        end
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    stim_done    = 1'b0;
    rst_n            = 1'b0;
    bus.alu_enable   = 1'b0;
    bus.alu_enable_a = 1'b0;
    bus.alu_enable_b = 1'b0;
    bus.alu_op_a     = 2'b00;
    bus.alu_op_b     = 2'b00;
    bus.alu_in_a     = 8'h00;
    bus.alu_in_b     = 8'h00;
    bus.alu_irq_clr  = 1'b0;

    //   rst en ea eb opa    opb    A      B      clr   out    irq src    err
    // Reset held with a pending event, then released.
    step(0, 1, 1, 0, 2'b10, 2'b00, 8'hF0, 8'h08, 0,    8'h00, 0, 8'h00, 0);
    step(0, 1, 1, 0, 2'b10, 2'b00, 8'hF0, 8'h08, 0,    8'h00, 0, 8'h00, 0);
    step(1, 1, 1, 0, 2'b10, 2'b00, 8'hF0, 8'h08, 0,    8'hF8, 1, 8'h04, 0);
    // Mode-a sweep (first vector also clears the reset-release interrupt).
    step(1, 1, 1, 0, 2'b00, 2'b00, 8'h3C, 8'h0F, 1,    8'h0C, 0, 8'h00, 0);
    step(1, 1, 1, 0, 2'b01, 2'b00, 8'h3C, 8'h0F, 0,    8'hF3, 0, 8'h00, 0);
    step(1, 1, 1, 0, 2'b10, 2'b00, 8'h3C, 8'h0F, 0,    8'h3F, 0, 8'h00, 0);
    step(1, 1, 1, 0, 2'b11, 2'b00, 8'h3C, 8'h0F, 0,    8'h33, 0, 8'h00, 0);
    // Sticky interrupt from mode-b op 11, held over three non-event ops, then cleared while idle.
    step(1, 1, 0, 1, 2'b00, 2'b11, 8'hF0, 8'h0F, 0,    8'hFF, 1, 8'h80, 0);
    step(1, 1, 1, 0, 2'b00, 2'b00, 8'h3C, 8'h0F, 0,    8'h0C, 1, 8'h80, 0);
    step(1, 1, 1, 0, 2'b11, 2'b00, 8'h3C, 8'h0F, 0,    8'h33, 1, 8'h80, 0);
    step(1, 1, 0, 1, 2'b00, 2'b01, 8'h3C, 8'h0F, 0,    8'h0C, 1, 8'h80, 0);
    step(1, 0, 0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1,    8'h0C, 0, 8'h00, 0);
    step(1, 0, 0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0,    8'h0C, 0, 8'h00, 0);
    // Clear/event collision: the new mode-b op 01 event wins, old mode-a flag dropped.
    step(1, 1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0,    8'hFF, 1, 8'h01, 0);
    step(1, 1, 0, 1, 2'b00, 2'b01, 8'hF4, 8'hFF, 1,    8'hF4, 1, 8'h20, 0);
    // Remaining mode-b events accumulate.
    step(1, 1, 0, 1, 2'b00, 2'b00, 8'hF0, 8'hFE, 0,    8'hF1, 1, 8'h30, 0);
    step(1, 1, 0, 1, 2'b00, 2'b10, 8'h0A, 8'h00, 0,    8'hF5, 1, 8'h70, 0);
    step(1, 1, 0, 1, 2'b00, 2'b10, 8'h0A, 8'h00, 0,    8'hF5, 1, 8'h70, 0);
    // Illegal selects and idle cycles hold the result.
    step(1, 1, 1, 0, 2'b10, 2'b00, 8'h55, 8'h00, 1,    8'h55, 0, 8'h00, 0);
    step(1, 1, 1, 1, 2'b00, 2'b11, 8'hFF, 8'hFF, 0,    8'h55, 0, 8'h00, 1);
    step(1, 0, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0,    8'h55, 0, 8'h00, 0);
    step(1, 0, 0, 1, 2'b00, 2'b11, 8'hF0, 8'h0F, 0,    8'h55, 0, 8'h00, 0);
    step(1, 1, 0, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0,    8'h55, 0, 8'h00, 1);
    step(1, 0, 0, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0,    8'h55, 0, 8'h00, 0);
    // Reset in the middle of an active interrupt, with an event pending on the inputs.
    step(1, 1, 0, 1, 2'b00, 2'b11, 8'hF0, 8'h0F, 0,    8'hFF, 1, 8'h80, 0);
    step(0, 1, 0, 1, 2'b00, 2'b11, 8'hF0, 8'h0F, 0,    8'h00, 0, 8'h00, 0);
    step(1, 0, 0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0,    8'h00, 0, 8'h00, 0);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    tests_failed++;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
